nios2os_nios2_oci_dct_ctrl: RTL

Controller for the OCI data-compression-trace (DCT) buffer. It packs 2-bit compressed trace symbols into the 30-bit DCT buffer, with up to 15 symbols per buffer. It arbitrates one trace output port between DCT packets and uncompressed direct trace words, keeping trace order. It also drives the end-of-test handshake, test_ending and test_has_ended, that the OCI test bench consumes.

---
 rtl/nios2os_nios2_oci_dct_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nios2os_nios2_oci_dct_ctrl.sv
// OCI DCT buffer controller: packs 2-bit trace symbols, arbitrates the
// trace output port in order, and drives the end-of-test handshake.
module nios2os_nios2_oci_dct_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trace_en,
  input  logic        trace_stop,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  output logic        sym_ready,
  input  logic        word_valid,
  input  logic [33:0] word,
  output logic        word_ready,
  input  logic        flush_req,
  output logic        out_valid,
  output logic [35:0] out_data,
  input  logic        out_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ENDED
  } state_t;

  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  state_t           state;
  logic             trace_en_q;
  logic [TMR_W-1:0] timer;
  logic             flush_pend;

  logic en_rise;
  logic run;
  logic drain;
  logic full;
  logic empty;
  logic tmo_hit;
  logic slot_free;
  logic dct_trig;
  logic emit_dct;
  logic emit_word;
  logic sym_acc;

  assign en_rise   = trace_en & ~trace_en_q;
  assign run       = (state == S_RUN);
  assign drain     = (state == S_DRAIN);
  assign full      = (dct_count == 4'd15);
  assign empty     = (dct_count == 4'd0);
  assign tmo_hit   = TMO_EN && (timer == TMO);
  assign slot_free = ~out_valid | out_ready;

  // Older symbols always leave before a waiting direct word.
  assign dct_trig  = ~empty &
                     (full | word_valid | flush_pend |
                      tmo_hit | drain);
  assign emit_dct  = slot_free & dct_trig;
  assign emit_word = slot_free & ~dct_trig &
                     word_valid & run;

  assign word_ready = emit_word;
  assign sym_ready  = run & ~full & ~word_valid;
  assign sym_acc    = sym_valid & sym_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      trace_en_q     <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      trace_en_q <= trace_en;
      unique case (state)
        S_IDLE: begin
          if (en_rise) state <= S_RUN;
        end
        S_RUN: begin
          if (trace_stop) begin
            state       <= S_DRAIN;
            test_ending <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (empty && !out_valid) begin
            state          <= S_ENDED;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b1;
          end
        end
        S_ENDED: begin
          if (en_rise) begin
            state          <= S_RUN;
            test_has_ended <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (slot_free) begin
      if (emit_dct) begin
        out_valid <= 1'b1;
        out_data  <= {2'b01, dct_count, dct_buffer};
      end else if (emit_word) begin
        out_valid <= 1'b1;
        out_data  <= {2'b10, word};
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // A symbol taken in an emit cycle starts the fresh buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (emit_dct) begin
      dct_buffer <= sym_acc ? {28'b0, sym} : '0;
      dct_count  <= sym_acc ? 4'd1 : 4'd0;
    end else if (sym_acc) begin
      dct_buffer <= {dct_buffer[27:0], sym};
      dct_count  <= dct_count + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else if (flush_req) begin
      flush_pend <= 1'b1;
    end else if (emit_dct || empty) begin
      flush_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (sym_acc || emit_dct || empty) begin
      timer <= '0;
    end else if (timer != TMO) begin
      timer <= timer + 1'b1;
    end
  end

endmodule
